// File: rtl/seqcheck.sv
// seqcheck: counts synchronized rising edges over a sliding W-cycle window and pulses hit on each upward crossing of K
module seqcheck #(
    parameter int W = 5,
    parameter int K = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_sig,
    output logic hit
);
    localparam int IW = (W <= 2) ? 1 : $clog2(W);
    localparam int SW = (W <= 1) ? 1 : $clog2(W + 1);
    logic          s1, s2, prev, rise, cond_d, cond_next;
    logic [W-1:0]  rb;
    logic [IW-1:0] idx;
    logic [SW-1:0] sum, next_sum;
    // Edge detect and O(1) window update: the slot being overwritten leaves the window as the new rise enters
    always_comb begin
        rise      = s2 & ~prev;
        next_sum  = sum - SW'(rb[idx]) + SW'(rise);
        cond_next = next_sum >= SW'(K);
    end
    // Synchronizer, ring buffer, running sum and crossing detector
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            prev   <= 1'b0;
            sum    <= '0;
            idx    <= '0;
            rb     <= '0;
            cond_d <= 1'b0;
            hit    <= 1'b0;
        end else begin
            s1       <= in_sig;
            s2       <= s1;
            prev     <= s2;
            sum      <= next_sum;
            rb[idx]  <= rise;
            idx      <= (idx == IW'(W - 1)) ? '0 : idx + 1'b1;
            hit      <= cond_next & ~cond_d;
            cond_d   <= cond_next;
        end
    end
endmodule

// File: tb/tb_seqcheck.sv
// tb_seqcheck: directed scenarios checked cycle-by-cycle against a queue-window golden model via a scoreboard
module tb_seqcheck;
    localparam int W = 5;
    localparam int K = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_sig = 1'b0;
    logic hit;
    int   errors = 0;
    int   checks = 0;
    int   hits = 0;
    string tag = "reset";
    bit   m_s1, m_s2, m_prev, m_cd, m_hit;
    bit   hist[$];
    bit   exp_q[$];

    seqcheck #(.W(W), .K(K)) dut (
        .clk(clk),
        .rst(rst),
        .in_sig(in_sig),
        .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic r);
        bit nr, cn, e;
        int ns;
        in_sig = v;
        rst = r;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_cd = 0; m_hit = 0;
            hist.delete();
        end else begin
            nr = m_s2 & ~m_prev;
            hist.push_back(nr);
            if (hist.size() > W) void'(hist.pop_front());
            ns = 0;
            foreach (hist[i]) ns += int'(hist[i]);
            cn = ns >= K;
            m_hit = cn & ~m_cd;
            m_cd = cn;
            m_prev = m_s2;
            m_s2 = m_s1;
            m_s1 = v;
        end
        exp_q.push_back(m_hit);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (hit === e) else begin
            errors++;
            $error("FAIL %s hit observed=%b expected=%b t=%0t", tag, hit, e, $time);
        end
        if (hit === 1'b1) hits++;
    endtask

    task automatic run(input int n, input logic v);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    task automatic check_hits(input int want);
        checks++;
        assert (hits === want) else begin
            errors++;
            $error("FAIL %s hit_count observed=%0d expected=%0d", tag, hits, want);
        end
        hits = 0;
    endtask

    task automatic begin_scn(input string name);
        run(8, 1'b0);
        hits = 0;
        tag = name;
    endtask

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        assert (dut.sum === '0) else begin
            errors++;
            $error("FAIL reset_sum observed=%0d expected=0", dut.sum);
        end
        check_hits(0);

        begin_scn("three_pulses");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            if (i < 2) step(1'b0, 1'b0);
        end
        run(2, 1'b0);
        checks++;
        assert (hit === 1'b1) else begin
            errors++;
            $error("FAIL three_pulses_latency observed=%b expected=1", hit);
        end
        run(8, 1'b0);
        check_hits(1);

        begin_scn("sparse");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            run(W + 1, 1'b0);
        end
        check_hits(0);

        begin_scn("reset_mid");
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        run(2, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        assert (dut.sum === '0) else begin
            errors++;
            $error("FAIL reset_mid_sum observed=%0d expected=0", dut.sum);
        end
        step(1'b1, 1'b0);
        run(8, 1'b0);
        check_hits(0);

        begin_scn("long_high");
        run(7, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        run(8, 1'b0);
        check_hits(0);

        begin_scn("toggle");
        for (int i = 0; i < 16; i++) step(logic'(i % 2 == 0), 1'b0);
        run(W + 3, 1'b0);
        check_hits(6);

        begin_scn("low");
        run(20, 1'b0);
        check_hits(0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
